// File: rtl/hour_ctr_mode.sv
// hour_ctr_mode
//   Hour-of-day counter. Time is held as a 0-23 count; the display encoding
//   (12-hour or 24-hour) is chosen at run time by mode24 and never alters
//   the count itself. Display digits, AM/PM glyph, pm flag and the
//   day-rollover carry are all registered one edge behind the count.
//
//   Optional feature macro: HR_LZ_BLANK_EN
//     When defined, the tens digit is blanked in 12-hour mode for hours 1-9.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   cy_in     : hourly carry from the minutes stage (count up)
//   adv_hr    : manual advance (count up)
//   ret_hr    : manual retreat (count down)
//   mode24    : 1 = 24-hour display, 0 = 12-hour display
//   h1, h0    : BCD tens / ones of the displayed hour (h1 may be BLANK_CODE)
//   am_pm     : A_CODE, P_CODE, or BLANK_CODE in 24-hour mode
//   pm        : internal count is 12-23
//   cy_out    : one-cycle day-rollover pulse

module hour_ctr_mode #(
    parameter logic [4:0] RST_HOUR   = 5'd0,
    parameter logic [3:0] A_CODE     = 4'd10,
    parameter logic [3:0] P_CODE     = 4'd11,
    parameter logic [3:0] BLANK_CODE = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cy_in,
    input  logic       adv_hr,
    input  logic       ret_hr,
    input  logic       mode24,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] am_pm,
    output logic       pm,
    output logic       cy_out
);

    logic [4:0] hr_q, hr_d;
    logic       wrap_q, wrap_d;
    logic [3:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d;
    logic [3:0] am_pm_q, am_pm_d;
    logic       pm_q, pm_d;
    logic       cy_out_q, cy_out_d;

    logic       inc, dec;
    logic [4:0] disp;
    logic [4:0] ones;
    logic [3:0] tens;

    // Count update. Opposing requests cancel. Only a minutes-stage carry that
    // wraps 23->0 is a real day rollover; manual wraps are not.
    always_comb begin
        inc    = cy_in | adv_hr;
        dec    = ret_hr;
        hr_d   = hr_q;
        wrap_d = 1'b0;
        if (inc && !dec) begin
            hr_d   = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            wrap_d = cy_in && (hr_q == 5'd23);
        end else if (dec && !inc) begin
            hr_d   = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
        end
    end

    // Display mapping from the current count; the digit registers capture it.
    always_comb begin
        disp = hr_q;
        if (!mode24) begin
            if (hr_q == 5'd0 || hr_q == 5'd12) disp = 5'd12;
            else if (hr_q > 5'd12)             disp = hr_q - 5'd12;
        end

        if (disp >= 5'd20) begin
            tens = 4'd2;
            ones = disp - 5'd20;
        end else if (disp >= 5'd10) begin
            tens = 4'd1;
            ones = disp - 5'd10;
        end else begin
            tens = 4'd0;
            ones = disp;
        end

        h1_d = tens;
`ifdef HR_LZ_BLANK_EN
        if (!mode24 && tens == 4'd0) h1_d = BLANK_CODE;
`else
`endif
        h0_d     = ones[3:0];
        pm_d     = (hr_q >= 5'd12);
        am_pm_d  = mode24 ? BLANK_CODE : (pm_d ? P_CODE : A_CODE);
        cy_out_d = wrap_q;
    end

    // Reset display is the 12-hour midnight glyphs "12 A" whatever the mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_q     <= RST_HOUR;
            wrap_q   <= 1'b0;
            h1_q     <= 4'd1;
            h0_q     <= 4'd2;
            am_pm_q  <= A_CODE;
            pm_q     <= 1'b0;
            cy_out_q <= 1'b0;
        end else begin
            hr_q     <= hr_d;
            wrap_q   <= wrap_d;
            h1_q     <= h1_d;
            h0_q     <= h0_d;
            am_pm_q  <= am_pm_d;
            pm_q     <= pm_d;
            cy_out_q <= cy_out_d;
        end
    end

    assign h1     = h1_q;
    assign h0     = h0_q;
    assign am_pm  = am_pm_q;
    assign pm     = pm_q;
    assign cy_out = cy_out_q;

endmodule

// File: tb/tb_hour_ctr_mode.sv
module tb_hour_ctr_mode;

    localparam logic [3:0] AC = 4'd10;
    localparam logic [3:0] PC = 4'd11;
    localparam logic [3:0] BC = 4'd15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cy_in, adv_hr, ret_hr, mode24;
    logic [3:0] h1, h0, am_pm;
    logic       pm, cy_out;

    hour_ctr_mode dut (
        .clk(clk), .rst(rst), .cy_in(cy_in), .adv_hr(adv_hr), .ret_hr(ret_hr),
        .mode24(mode24), .h1(h1), .h0(h0), .am_pm(am_pm), .pm(pm), .cy_out(cy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] ap;
        logic       pm;
        logic       cy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that falls due on this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                checks = checks + 1;
                if (h1 !== sb[i].h1 || h0 !== sb[i].h0 || am_pm !== sb[i].ap ||
                    pm !== sb[i].pm || cy_out !== sb[i].cy) begin
                    errors = errors + 1;
                    $display("FAIL %s @cyc%0d: got h1=%0d h0=%0d ap=%0d pm=%b cy=%b want h1=%0d h0=%0d ap=%0d pm=%b cy=%b",
                             sb[i].name, cyc, h1, h0, am_pm, pm, cy_out,
                             sb[i].h1, sb[i].h0, sb[i].ap, sb[i].pm, sb[i].cy);
                end
                sb.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    // Hand-written tens digit for a 12-hour display value.
    function automatic logic [3:0] t12(input int h12);
`ifdef HR_LZ_BLANK_EN
        return (h12 < 10) ? BC : 4'(h12 / 10);
`else
        return 4'(h12 / 10);
`endif
    endfunction

    task automatic push(input int lat, input logic [3:0] e1, input logic [3:0] e0,
                        input logic [3:0] ap, input logic epm, input logic ecy,
                        input string nm);
        exp_t e;
        e.due = cyc + lat; e.h1 = e1; e.h0 = e0; e.ap = ap;
        e.pm = epm; e.cy = ecy; e.name = nm;
        sb.push_back(e);
    endtask

    // One request cycle; its effect is visible two edges later.
    task automatic step(input logic c, input logic a, input logic r,
                        input logic [3:0] e1, input logic [3:0] e0, input logic [3:0] ap,
                        input logic epm, input logic ecy, input string nm);
        cy_in = c; adv_hr = a; ret_hr = r;
        push(2, e1, e0, ap, epm, ecy, nm);
        @(negedge clk);
        cy_in = 0; adv_hr = 0; ret_hr = 0;
    endtask

    // Mode change; visible one edge later. Extra idle cycle keeps it clean.
    task automatic mstep(input logic m, input logic [3:0] e1, input logic [3:0] e0,
                         input logic [3:0] ap, input logic epm, input string nm);
        @(negedge clk);
        mode24 = m;
        push(1, e1, e0, ap, epm, 1'b0, nm);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic idle2;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int h, h12;
        rst = 1; cy_in = 0; adv_hr = 0; ret_hr = 0; mode24 = 1;
        repeat (2) @(negedge clk);
        push(1, 4'd1, 4'd2, AC, 1'b0, 1'b0, "reset_in_24");
        @(negedge clk);
        mode24 = 0;
        @(negedge clk);
        rst = 0;
        push(1, 4'd1, 4'd2, AC, 1'b0, 1'b0, "reset_release_12");
        @(negedge clk);
        mstep(1'b1, 4'd0, 4'd0, BC, 1'b0, "mode24_midnight");
        mstep(1'b0, 4'd1, 4'd2, AC, 1'b0, "mode12_midnight");

        // Full day of minutes carries, back to back.
        for (int i = 1; i <= 24; i++) begin
            h   = i % 24;
            h12 = (h % 12 == 0) ? 12 : h % 12;
            step(1, 0, 0, t12(h12), 4'(h12 % 10), (h >= 12) ? PC : AC,
                 h >= 12, i == 24, $sformatf("day_%0d", i));
        end
        idle2;

        // Retreat wrap 0 -> 23, then view in 24h and back.
        step(0, 0, 1, 4'd1, 4'd1, PC, 1'b1, 1'b0, "ret_wrap");
        idle2;
        mstep(1'b1, 4'd2, 4'd3, BC, 1'b1, "ret_wrap_24");
        mstep(1'b0, 4'd1, 4'd1, PC, 1'b1, "ret_wrap_12");
        // Manual advance wrap: no carry out.
        step(0, 1, 0, 4'd1, 4'd2, AC, 1'b0, 1'b0, "adv_wrap");
        idle2;

        for (int i = 1; i <= 5; i++)
            step(0, 1, 0, t12(i), 4'(i), AC, 1'b0, 1'b0, $sformatf("adv_%0d", i));
        step(1, 1, 0, t12(6), 4'd6, AC, 1'b0, 1'b0, "cy_plus_adv");
        step(0, 1, 1, t12(6), 4'd6, AC, 1'b0, 1'b0, "adv_plus_ret");
        for (int i = 7; i <= 23; i++) begin
            h12 = (i > 12) ? i - 12 : i;
            step(0, 1, 0, t12(h12), 4'(h12 % 10), (i >= 12) ? PC : AC, i >= 12, 1'b0,
                 $sformatf("adv_to_%0d", i));
        end
        step(1, 0, 1, 4'd1, 4'd1, PC, 1'b1, 1'b0, "cy_plus_ret_23");
        idle2;
        push(0, 4'd1, 4'd1, PC, 1'b1, 1'b0, "no_late_cy");
        for (int i = 22; i >= 15; i--) begin
            h12 = i - 12;
            step(0, 0, 1, t12(h12), 4'(h12 % 10), PC, 1'b1, 1'b0,
                 $sformatf("ret_to_%0d", i));
        end
        idle2;
        mstep(1'b1, 4'd1, 4'd5, BC, 1'b1, "mode_15_24");
        mstep(1'b0, t12(3), 4'd3, PC, 1'b1, "mode_15_12");

        // Go to 23 then reset right after a carry wrap: no cy_out pulse.
        for (int i = 16; i <= 23; i++)
            step(0, 1, 0, t12(i - 12), 4'((i - 12) % 10), PC, 1'b1, 1'b0,
                 $sformatf("up_%0d", i));
        idle2;
        cy_in = 1;
        @(posedge clk);
        #1;
        cy_in = 0;
        rst   = 1;
        push(1, 4'd1, 4'd2, AC, 1'b0, 1'b0, "midop_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        push(2, 4'd1, 4'd2, AC, 1'b0, 1'b0, "after_midop_reset");
        idle2;

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/hour_ctr_mode.md
# hour_ctr_mode

Hour-of-day counter with run-time selectable 12-hour or 24-hour display, manual advance and retreat, and a day-rollover carry. Time is always held internally as a 0–23 count, so a mode change never changes the time. The block sits between the minutes stage, which supplies the hourly carry, and the seven-segment display mux, which receives registered BCD digits plus an AM/PM glyph code.

## Interface

- `RST_HOUR`, default 0: hour count (0–23, 24-hour form) loaded on reset.
- `A_CODE`, default 4'd10: display glyph code for "A".
- `P_CODE`, default 4'd11: display glyph code for "P".
- `BLANK_CODE`, default 4'd15: display glyph code for a dark digit.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `cy_in`  in  1  one-cycle carry from the minutes stage; counts the hour up by one.
- `adv_hr`  in  1  one-cycle manual advance (already rate-limited upstream); counts up by one.
- `ret_hr`  in  1  one-cycle manual retreat; counts down by one.
- `mode24`  in  1  1 selects 24-hour display, 0 selects 12-hour display.
- `h1`  out  4  BCD tens digit of the displayed hour, or `BLANK_CODE`.
- `h0`  out  4  BCD ones digit of the displayed hour.
- `am_pm`  out  4  `A_CODE`, `P_CODE` or `BLANK_CODE`.
- `pm`  out  1  1 when the internal count is 12–23; valid in both modes.
- `cy_out`  out  1  one-cycle day-rollover pulse to the day stage.

## Operation

- The internal register `hr` is 5 bits wide and always holds a value from 0 to 23.
- Increment request: `inc = cy_in | adv_hr`. If `cy_in` and `adv_hr` are high in the same cycle, the count still moves by one step only.
- Decrement request: `dec = ret_hr`.
- Priority and result per edge:
  - `inc & dec`: no change.
  - `inc` only: `hr <= (hr==23) ? 0 : hr+1`.
  - `dec` only: `hr <= (hr==0) ? 23 : hr-1`.
  - neither: hold.
- Rollover carry: `cy_out` pulses only on a 23→0 wrap caused by `cy_in` with no `ret_hr` in the same cycle.
  - A wrap caused by `adv_hr` alone does not pulse `cy_out`.
  - A retreat wrap from 0 to 23 does not pulse `cy_out`.
- Display mapping, computed from the current `hr` and `mode24`:
  - 24-hour mode: digits show `hr` as 00–23; `am_pm = BLANK_CODE`.
  - 12-hour mode: `h12 = hr mod 12`, except that 0 maps to 12. `am_pm` is `P_CODE` when `hr ≥ 12`, otherwise `A_CODE`.
- BCD conversion is combinational from the value being displayed (at most 23). The digit registers capture the result.
- AM/PM is a pure function of `hr`. There is no separate AM/PM flip-flop, so the count and the indicator cannot desynchronise.
- Switching `mode24` mid-operation leaves `hr` untouched. Only the output encoding changes.

## Timing

- Reset (asynchronous) sets:
  - `hr = RST_HOUR`, `cy_out = 0`.
  - `h1 = 4'd1`, `h0 = 4'd2`, `am_pm = A_CODE`, `pm = 0`.
- These digit values are the 12-hour midnight display, regardless of `mode24`. The first clock edge after reset release loads values that match the current mode.
- `hr` updates on the edge where the request is sampled.
- `h1`, `h0`, `am_pm`, `pm` and `cy_out` are registered and change one edge after `hr`, so display latency is 2 edges from the request.
- Consecutive requests on every cycle are legal. Each one is applied, and the outputs follow in a pipelined fashion.
- A reset asserted mid-operation overrides any request in flight, and no `cy_out` pulse is produced.
- A `mode24` change is reflected on the outputs one edge later.

## Configuration

- `HR_LZ_BLANK_EN`, when defined: in 12-hour mode, if the tens digit is 0 (hours 1–9), `h1` is driven to `BLANK_CODE`.
  - 24-hour mode always shows the leading zero.
  - The reset value of `h1` is unaffected, because "12" has no leading zero.
- When not defined: `h1` always carries a BCD digit, so 12-hour mode shows 01–09.

## Test plan

- Reset check: hold `rst`, then release with `mode24=0`. Expect `h1/h0/am_pm = 1/2/A`. Set `mode24=1`. One edge later expect `0/0/BLANK`.
- Full-day carry: pulse `cy_in` 24 times, 12-hour mode.
  - Display sequence: 12A, 1A…11A, 12P, 1P…11P, 12A.
  - `pm` rises after the 12th pulse.
  - `cy_out` pulses exactly once, one edge after the 24th `hr` update.
- Retreat wrap and manual advance:
  - From `hr=0`, pulse `ret_hr`: expect `hr=23` (11P, or 23 in 24-hour mode) and `cy_out=0`.
  - Then pulse `adv_hr`: expect `hr=0` and `cy_out=0`.
- Simultaneous requests at `hr=5`:
  - `cy_in` + `adv_hr` in the same cycle: expect `hr=6`.
  - `adv_hr` + `ret_hr` in the same cycle: expect `hr=6` (unchanged).
  - `cy_in` + `ret_hr` at `hr=23`: expect `hr=23` and no `cy_out`.
- Mode switch at `hr=15`: toggle `mode24` 0→1→0. Outputs go 3/P → 15/BLANK → 3/P, each one edge after the toggle, and `hr` stays at 15.
- Blanking macro, with `HR_LZ_BLANK_EN` defined, 12-hour mode:
  - `hr=7`: expect `h1=BLANK_CODE`, `h0=7`.
  - `hr=22`: expect `h1=1`, `h0=0`.
  - Without the macro, `hr=7` gives `h1=0`.
